// File: rtl/music_player.sv
// Song sequencer stepping a registered note ROM at a fixed tempo and driving a 50 % duty square wave.
// Define MUSIC_PLAYER_PAUSE_EN to add a pause input that freezes playback in place.
module music_player #(
   parameter int NOTE_W         = 32,
   parameter int DEPTH          = 384,
   parameter int NUM_SONGS      = 4,
   parameter int TICKS_PER_BEAT = 6_250_000,
   parameter int ROM_LAT        = 1,
   parameter int REST_CODE      = 2500,
   localparam int SONG_W        = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
   localparam int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int BEAT_W        = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
`ifdef MUSIC_PLAYER_PAUSE_EN
   input  logic              pause,
`endif
   input  logic [SONG_W-1:0] song_sel,
   output logic [SONG_W-1:0] rom_song,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [NOTE_W-1:0] rom_note,
   output logic              buzzer,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      DRAIN
   } state_e;

   localparam logic [SONG_W:0]   SONGS_LIM  = (SONG_W+1)'(NUM_SONGS);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(TICKS_PER_BEAT - 1);
   localparam logic [BEAT_W-1:0] BEAT_LOAD  = BEAT_W'(ROM_LAT);
   localparam logic [BEAT_W-1:0] DRAIN_LAST = BEAT_W'(ROM_LAT - 1);
   localparam logic [NOTE_W-1:0] REST_NOTE  = NOTE_W'(REST_CODE);

   state_e              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [SONG_W-1:0]   song_q, song_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [NOTE_W-1:0]   period_q, period_d;
   logic [NOTE_W-1:0]   periodNext;
   logic                buzzer_q, buzzer_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                paused;
   logic                songOk;

   function automatic logic isSilent(input logic [NOTE_W-1:0] n);
      return (n == '0) || (n == REST_NOTE);
   endfunction

`ifdef MUSIC_PLAYER_PAUSE_EN
   assign paused = pause && (state_q != IDLE);
`else
   assign paused = 1'b0;
`endif

   assign songOk = ({1'b0, song_sel} < SONGS_LIM);

   // Silent notes park the phase at 0 so the next audible note starts cleanly.
   always_comb begin
      periodNext = '0;
      if (!isSilent(note_q) && (period_q < note_q - NOTE_W'(1))) begin
         periodNext = period_q + NOTE_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      addr_d   = addr_q;
      song_d   = song_q;
      note_d   = note_q;
      period_d = period_q;
      done_d   = 1'b0;
      if (stop) begin
         state_d  = IDLE;
         beat_d   = '0;
         note_d   = '0;
         period_d = '0;
      end else if (!paused) begin
         case (state_q)
            IDLE: begin
               if (start && songOk) begin
                  state_d  = PLAY;
                  song_d   = song_sel;
                  addr_d   = '0;
                  beat_d   = '0;
                  note_d   = '0;
                  period_d = '0;
               end
            end
            PLAY: begin
               period_d = periodNext;
               // Restarting the phase only on a changed note keeps repeated entries seamless.
               if (beat_q == BEAT_LOAD) begin
                  note_d = rom_note;
                  if (rom_note != note_q) begin
                     period_d = '0;
                  end
               end
               if (beat_q == BEAT_LAST) begin
                  beat_d = '0;
                  if (addr_q != ADDR_LAST) begin
                     addr_d = addr_q + ADDR_W'(1);
                  end else if (loop) begin
                     addr_d = '0;
                  end else if (ROM_LAT == 0) begin
                     state_d  = IDLE;
                     done_d   = 1'b1;
                     note_d   = '0;
                     period_d = '0;
                  end else begin
                     state_d = DRAIN;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
            DRAIN: begin
               period_d = periodNext;
               if (beat_q == DRAIN_LAST) begin
                  state_d  = IDLE;
                  done_d   = 1'b1;
                  beat_d   = '0;
                  note_d   = '0;
                  period_d = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d   = (state_d != IDLE);
      buzzer_d = busy_d && !paused && !isSilent(note_d) && (period_d < (note_d >> 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         addr_q   <= '0;
         song_q   <= '0;
         note_q   <= '0;
         period_q <= '0;
         buzzer_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         addr_q   <= addr_d;
         song_q   <= song_d;
         note_q   <= note_d;
         period_q <= period_d;
         buzzer_q <= buzzer_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign rom_song = song_q;
   assign rom_addr = addr_q;
   assign buzzer   = buzzer_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_music_player.sv
// Self-checking bench for music_player: a timeline model predicts every output cycle by cycle.
// Pause scenarios are compiled in when MUSIC_PLAYER_PAUSE_EN is defined.
module tb_music_player;

   localparam int NOTE_W    = 32;
   localparam int DEPTH     = 4;
   localparam int NUM_SONGS = 2;
   localparam int TPB       = 8;
   localparam int ROM_LAT   = 1;
   localparam int REST      = 2500;
   localparam int SONG_LEN  = DEPTH * TPB;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, stop, loop;
   logic [0:0]        songSel;
   logic [0:0]        romSong;
   logic [1:0]        romAddr;
   logic [NOTE_W-1:0] romNote = '0;
   logic              buzzer, busy, done;
`ifdef MUSIC_PLAYER_PAUSE_EN
   logic              pause;
`endif

   logic              startB, stopB;
   logic [1:0]        songSelB, romSongB, romAddrB;
   logic [NOTE_W-1:0] romNoteB = '0;
   logic              buzzerB, busyB, doneB;

   int romTable [0:NUM_SONGS*DEPTH-1];
   int seq [$];
   int testCount = 0;
   int failCount = 0;

   music_player #(
      .NOTE_W(NOTE_W), .DEPTH(DEPTH), .NUM_SONGS(NUM_SONGS),
      .TICKS_PER_BEAT(TPB), .ROM_LAT(ROM_LAT), .REST_CODE(REST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
`ifdef MUSIC_PLAYER_PAUSE_EN
      .pause(pause),
`endif
      .song_sel(songSel), .rom_song(romSong), .rom_addr(romAddr), .rom_note(romNote),
      .buzzer(buzzer), .busy(busy), .done(done)
   );

   // Three-song variant so an out-of-range selection is representable on the port.
   music_player #(
      .NOTE_W(NOTE_W), .DEPTH(DEPTH), .NUM_SONGS(3),
      .TICKS_PER_BEAT(TPB), .ROM_LAT(ROM_LAT), .REST_CODE(REST)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .start(startB), .stop(stopB), .loop(1'b0),
`ifdef MUSIC_PLAYER_PAUSE_EN
      .pause(1'b0),
`endif
      .song_sel(songSelB), .rom_song(romSongB), .rom_addr(romAddrB), .rom_note(romNoteB),
      .buzzer(buzzerB), .busy(busyB), .done(doneB)
   );

   always #5 clk = ~clk;

   // Registered ROM with one cycle of latency.
   always @(posedge clk) begin
      romNote <= romTable[{romSong, romAddr}];
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired after %0d tests", testCount);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic p, input logic l, input logic [0:0] sel);
      start   = s;
      stop    = p;
      loop    = l;
      songSel = sel;
   endtask

   // Expected outputs t cycles after acceptance, from the song timeline: entry g owns the address
   // for cycles [g*TPB, (g+1)*TPB) and is heard ROM_LAT+1 cycles later; runs of equal notes share one phase.
   task automatic modelAt(input int t, input int passes, output logic eBusy, output logic eDone,
                          output logic eBuzz, output int eAddr);
      int total, lastT, g, n, r, st;
      total = passes * DEPTH;
      lastT = total * TPB + ROM_LAT;
      eBusy = (t < lastT);
      eDone = (t == lastT);
      eBuzz = 1'b0;
      g = t / TPB;
      if (g > total - 1) g = total - 1;
      eAddr = g % DEPTH;
      if (t < lastT && t >= ROM_LAT + 1) begin
         g = (t - ROM_LAT - 1) / TPB;
         n = seq[g];
         if (n != 0 && n != REST) begin
            r = g;
            while (r > 0 && seq[r-1] == n) r--;
            st = r * TPB + ROM_LAT + 1;
            eBuzz = (((t - st) % n) < (n / 2));
         end
      end
   endtask

   task automatic playSong(input int song, input int passes, input int stopAt,
                           input int pauseAt, input int pauseLen, input bit noise);
      int lastT, limit, pc, eff, eAddr;
      logic eBusy, eDone, eBuzz;
      bit pauseNow, pauseNext, stopNext, loopNext, startNext;
      logic [0:0] selNext;
      seq.delete();
      for (int p = 0; p < passes; p++)
         for (int e = 0; e < DEPTH; e++)
            seq.push_back(romTable[song*DEPTH + e]);
      lastT = passes * SONG_LEN + ROM_LAT;
      limit = (stopAt >= 0) ? stopAt + 2 : lastT + pauseLen + 2;
      pc = 0;
      pauseNow = 1'b0;
      applyStimulus(1'b1, 1'b0, passes > 1, 1'(song));
      for (int k = 0; k <= limit; k++) begin
         @(posedge clk);
         #1;
         if (pauseNow) pc++;
         eff = k - pc;
         if (stopAt >= 0 && k >= stopAt) begin
            eBusy = 1'b0; eDone = 1'b0; eBuzz = 1'b0; eAddr = 0;
         end else begin
            modelAt(eff, passes, eBusy, eDone, eBuzz, eAddr);
            if (pauseNow) begin
               eBuzz = 1'b0;
               eDone = 1'b0;
            end
         end
         checkOutput("busy", 32'(busy), 32'(eBusy));
         checkOutput("done", 32'(done), 32'(eDone));
         checkOutput("buzzer", 32'(buzzer), 32'(eBuzz));
         if (eBusy) begin
            checkOutput("rom_addr", 32'(romAddr), 32'(eAddr));
            checkOutput("rom_song", 32'(romSong), 32'(song));
         end
         stopNext  = (k + 1 == stopAt);
         pauseNext = (k + 1 >= pauseAt) && (k + 1 < pauseAt + pauseLen);
         loopNext  = (eff / SONG_LEN) < (passes - 1);
         startNext = 1'b0;
         selNext   = 1'(song);
         if (noise && eff <= lastT - 2 && (stopAt < 0 || k + 1 <= stopAt) && $urandom_range(0, 3) == 0) begin
            startNext = 1'b1;
            selNext   = 1'($urandom_range(0, 1));
         end
         applyStimulus(startNext, stopNext, loopNext, selNext);
`ifdef MUSIC_PLAYER_PAUSE_EN
         pause = pauseNext;
`endif
         pauseNow = pauseNext;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MUSIC_PLAYER_PAUSE_EN
      pause = 1'b0;
`endif
   endtask

   initial begin
      int pool [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 2500};
      int passes, stopAt;
      rst_n    = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      startB   = 1'b0;
      stopB    = 1'b0;
      songSelB = 2'd0;
`ifdef MUSIC_PLAYER_PAUSE_EN
      pause = 1'b0;
`endif
      romTable = '{4, 4, 0, 6, 2, 2500, 2, 2};
      #12;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset buzzer", 32'(buzzer), 32'd0);
      checkOutput("reset rom_addr", 32'(romAddr), 32'd0);
      checkOutput("reset rom_song", 32'(romSong), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] song 0 single shot");
      playSong(0, 1, -1, 0, 0, 1'b0);
      $display("[TB] song 0 looped, loop released in last pass");
      playSong(0, 2, -1, 0, 0, 1'b0);
      playSong(0, 3, -1, 0, 0, 1'b0);
      $display("[TB] song 1 rest handling");
      playSong(1, 1, -1, 0, 0, 1'b0);
      $display("[TB] stop during entry 2");
      playSong(0, 1, 2*TPB + 3, 0, 0, 1'b0);

      $display("[TB] start together with stop in idle");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("start+stop busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("start+stop stays idle", 32'(busy), 32'd0);

      $display("[TB] song select range on three-song variant");
      songSelB = 2'd3;
      startB   = 1'b1;
      @(posedge clk);
      #1;
      startB = 1'b0;
      checkOutput("sel 3 ignored busy", 32'(busyB), 32'd0);
      checkOutput("sel 3 ignored done", 32'(doneB), 32'd0);
      songSelB = 2'd2;
      startB   = 1'b1;
      @(posedge clk);
      #1;
      startB = 1'b0;
      checkOutput("sel 2 accepted busy", 32'(busyB), 32'd1);
      checkOutput("sel 2 rom_song", 32'(romSongB), 32'd2);
      checkOutput("sel 2 rom_addr", 32'(romAddrB), 32'd0);
      checkOutput("silent rom buzzer", 32'(buzzerB), 32'd0);
      stopB = 1'b1;
      @(posedge clk);
      #1;
      stopB = 1'b0;
      checkOutput("variant stop busy", 32'(busyB), 32'd0);

      $display("[TB] asynchronous reset mid-song");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (19) @(posedge clk);
      #1;
      checkOutput("pre-reset busy", 32'(busy), 32'd1);
      checkOutput("pre-reset rom_addr", 32'(romAddr), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset busy", 32'(busy), 32'd0);
      checkOutput("async reset buzzer", 32'(buzzer), 32'd0);
      checkOutput("async reset done", 32'(done), 32'd0);
      checkOutput("async reset rom_addr", 32'(romAddr), 32'd0);
      checkOutput("async reset rom_song", 32'(romSong), 32'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifdef MUSIC_PLAYER_PAUSE_EN
      $display("[TB] pause for 5 cycles at beat 3");
      playSong(0, 1, -1, 4, 5, 1'b0);
      playSong(1, 2, -1, 13, 3, 1'b0);
`endif

      $display("[TB] randomized songs");
      for (int round = 0; round < 8; round++) begin
         for (int i = 0; i < NUM_SONGS*DEPTH; i++) begin
            if (i % DEPTH != 0 && $urandom_range(0, 2) == 0) romTable[i] = romTable[i-1];
            else romTable[i] = pool[$urandom_range(0, 8)];
         end
         passes = $urandom_range(1, 2);
         stopAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, passes * SONG_LEN) : -1;
         playSong($urandom_range(0, 1), passes, stopAt, 0, 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
